alu: RTL and testbench



---
 rtl/alu.sv | 104 ++++++++++
 tb/tb_alu.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 16-bit WISC ALU: combinational result path with registered zero/overflow/negative flags.
// Define ALU_SATURATE_EN to make ADD and SUB saturate on signed overflow instead of wrapping.
module alu (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] result,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  cmd,
    output logic        zero,
    output logic        ovfl,
    output logic        neg
);

    localparam logic [3:0] OpAdd    = 4'd0;
    localparam logic [3:0] OpPaddsb = 4'd1;
    localparam logic [3:0] OpSub    = 4'd2;
    localparam logic [3:0] OpAnd    = 4'd3;
    localparam logic [3:0] OpNor    = 4'd4;
    localparam logic [3:0] OpSll    = 4'd5;
    localparam logic [3:0] OpSrl    = 4'd6;
    localparam logic [3:0] OpSra    = 4'd7;
    localparam logic [3:0] OpLhb    = 4'd8;

    logic [15:0] sum;
    logic [15:0] diff;
    logic        add_ovf;
    logic        sub_ovf;
    logic [15:0] add_res;
    logic [15:0] sub_res;
    logic [3:0]  shamt;

    // Four independent signed nibble adds, each clamped to 0x7 / 0x8.
    function automatic logic [15:0] paddsb(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] r;
        logic [3:0]  nx;
        logic [3:0]  ny;
        logic [3:0]  ns;
        r = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            nx = x[i*4 +: 4];
            ny = y[i*4 +: 4];
            ns = nx + ny;
            if ((nx[3] == ny[3]) && (ns[3] != nx[3])) begin
                ns = nx[3] ? 4'h8 : 4'h7;
            end
            r[i*4 +: 4] = ns;
        end
        return r;
    endfunction

    always_comb begin
        sum     = a + b;
        diff    = a + ~b + 16'd1;
        add_ovf = (a[15] == b[15]) && (sum[15] != a[15]);
        sub_ovf = (a[15] != b[15]) && (diff[15] != a[15]);
        shamt   = b[3:0];
`ifdef ALU_SATURATE_EN
        // On overflow the true sign is a's sign, so clamp toward it.
        add_res = add_ovf ? {a[15], {15{~a[15]}}} : sum;
        sub_res = sub_ovf ? {a[15], {15{~a[15]}}} : diff;
`else
        add_res = sum;
        sub_res = diff;
`endif
    end

    always_comb begin
        result = 16'h0000;
        case (cmd)
            OpAdd:    result = add_res;
            OpPaddsb: result = paddsb(a, b);
            OpSub:    result = sub_res;
            OpAnd:    result = a & b;
            OpNor:    result = ~(a | b);
            OpSll:    result = a << shamt;
            OpSrl:    result = a >> shamt;
            OpSra:    result = 16'($signed(a) >>> shamt);
            OpLhb:    result = {b[7:0], a[7:0]};
            default:  result = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero <= 1'b0;
            ovfl <= 1'b0;
            neg  <= 1'b0;
        end else begin
            // Only cmd 0-7 touch zero; cmd 8-15 leave every flag alone.
            if (!cmd[3]) begin
                zero <= (result == 16'h0000);
            end
            if (cmd == OpAdd) begin
                ovfl <= add_ovf;
                neg  <= result[15];
            end else if (cmd == OpSub) begin
                ovfl <= sub_ovf;
                neg  <= result[15];
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed table, exhaustive small-value ADD sweep, flag/reset
// sequences and random vectors checked against an integer-arithmetic reference model.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] result;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  cmd;
    logic        zero;
    logic        ovfl;
    logic        neg;

    int n_vec = 0;
    int n_err = 0;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .result (result),
        .a      (a),
        .b      (b),
        .cmd    (cmd),
        .zero   (zero),
        .ovfl   (ovfl),
        .neg    (neg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic        ovf;
        logic        upd_z;
        logic        upd_vn;
    } ref_t;

    function automatic int sext16(input logic [15:0] x);
        int v;
        v = int'(x);
        if (v > 32767) v = v - 65536;
        return v;
    endfunction

    function automatic logic [15:0] wrap16(input longint v);
        logic [63:0] t;
        t = v;
        return t[15:0];
    endfunction

    function automatic logic [15:0] add_like(input int s);
`ifdef ALU_SATURATE_EN
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return wrap16(longint'(s));
    endfunction

    function automatic ref_t ref_alu(input logic [3:0] c, input logic [15:0] x,
                                     input logic [15:0] y);
        ref_t r;
        int sx, sy, s, sh, d, na, nb, acc;
        sx = sext16(x);
        sy = sext16(y);
        sh = int'(y[3:0]);
        d  = 2 ** sh;
        r.res    = 16'h0000;
        r.ovf    = 1'b0;
        r.upd_z  = (int'(c) < 8);
        r.upd_vn = (c == 4'd0) || (c == 4'd2);
        case (int'(c))
            0: begin
                s = sx + sy;
                r.ovf = (s > 32767) || (s < -32768);
                r.res = add_like(s);
            end
            1: begin
                acc = 0;
                for (int i = 0; i < 4; i++) begin
                    na = (int'(x) / (16 ** i)) % 16;
                    nb = (int'(y) / (16 ** i)) % 16;
                    if (na > 7) na = na - 16;
                    if (nb > 7) nb = nb - 16;
                    s = na + nb;
                    if (s > 7) s = 7;
                    if (s < -8) s = -8;
                    acc = acc + ((s + 16) % 16) * (16 ** i);
                end
                r.res = wrap16(longint'(acc));
            end
            2: begin
                s = sx - sy;
                r.ovf = (s > 32767) || (s < -32768);
                r.res = add_like(s);
            end
            3: r.res = x & y;
            4: r.res = ~(x | y);
            5: r.res = wrap16(longint'(x) * longint'(d));
            6: r.res = wrap16(longint'(int'(x) / d));
            7: begin
                if (sx >= 0) s = sx / d;
                else s = -((-sx + d - 1) / d);
                r.res = wrap16(longint'(s));
            end
            8: r.res = wrap16(longint'((int'(y) % 256) * 256 + (int'(x) % 256)));
            default: r.res = 16'h0000;
        endcase
        return r;
    endfunction

    // Reference flags, advanced on every rising edge from whatever the DUT inputs are.
    logic mz, mv, mn;
    ref_t mr;
    always @(posedge clk) begin
        mr = ref_alu(cmd, a, b);
        if (rst) begin
            mz <= 1'b0;
            mv <= 1'b0;
            mn <= 1'b0;
        end else begin
            if (mr.upd_z) mz <= (mr.res == 16'h0000);
            if (mr.upd_vn) begin
                mv <= mr.ovf;
                mn <= mr.res[15];
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cmd=%0d a=%h b=%h)", name, act, exp, cmd, a, b);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        cmd = c;
        a   = x;
        b   = y;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string name, input logic ez, input logic ev, input logic en);
        chk({name, ".zero"}, {15'd0, zero}, {15'd0, ez});
        chk({name, ".ovfl"}, {15'd0, ovfl}, {15'd0, ev});
        chk({name, ".neg"},  {15'd0, neg},  {15'd0, en});
    endtask

    typedef struct {
        string       name;
        logic [3:0]  c;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] res;
    } vec_t;

    vec_t tbl[$];
    ref_t rr;
    logic sat;

    initial begin
`ifdef ALU_SATURATE_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        tbl.push_back('{"paddsb",     4'd1,  16'h7171, 16'h1F1F, 16'h7070});
        tbl.push_back('{"sll1",       4'd5,  16'h8001, 16'h0001, 16'h0002});
        tbl.push_back('{"srl4",       4'd6,  16'h8001, 16'h0004, 16'h0800});
        tbl.push_back('{"sra4",       4'd7,  16'h8001, 16'h0004, 16'hF800});
        tbl.push_back('{"sll0",       4'd5,  16'h8001, 16'h0000, 16'h8001});
        tbl.push_back('{"srl0",       4'd6,  16'h8001, 16'h0000, 16'h8001});
        tbl.push_back('{"sra0",       4'd7,  16'h8001, 16'h0000, 16'h8001});
        tbl.push_back('{"sll_hi_b",   4'd5,  16'h8001, 16'hFFF1, 16'h0002});
        tbl.push_back('{"and",        4'd3,  16'hF0F0, 16'h0FF3, 16'h00F0});
        tbl.push_back('{"nor",        4'd4,  16'hF0F0, 16'h0FF3, 16'h000C});
        tbl.push_back('{"lhb",        4'd8,  16'hF0F0, 16'h0FF3, 16'hF3F0});
        tbl.push_back('{"rsv12",      4'd12, 16'hF0F0, 16'h0FF3, 16'h0000});
        tbl.push_back('{"add_wrap",   4'd0,  16'hFFFF, 16'h0001, 16'h0000});
        tbl.push_back('{"sub_ovf",    4'd2,  16'h8000, 16'h0001, sat ? 16'h8000 : 16'h7FFF});

        rst = 1'b1;
        cmd = 4'd0;
        a   = 16'h0000;
        b   = 16'h0000;
        tick();
        tick();
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].x, tbl[i].y);
            chk({"tbl.", tbl[i].name}, result, tbl[i].res);
            tick();
            chk_flags({"tbl.", tbl[i].name}, mz, mv, mn);
        end

        // ADD wrap to zero
        drive(4'd0, 16'hFFFF, 16'h0001);
        tick();
        chk_flags("add_ffff_1", 1'b1, 1'b0, 1'b0);

        // SUB signed overflow, then a reserved opcode must hold all flags
        drive(4'd2, 16'h8000, 16'h0001);
        tick();
        chk_flags("sub_8000_1", 1'b0, 1'b1, sat);
        drive(4'd12, 16'h1234, 16'h1234);
        chk("rsv12_res", result, 16'h0000);
        tick();
        chk_flags("rsv12_hold", 1'b0, 1'b1, sat);

        // Reset clears flags set by an ADD overflow and beats a same-cycle update
        drive(4'd0, 16'h7FFF, 16'h0001);
        tick();
        chk_flags("add_7fff_1", 1'b0, 1'b1, ~sat);
        rst = 1'b1;
        tick();
        chk_flags("rst_clear", 1'b0, 1'b0, 1'b0);
        drive(4'd2, 16'h5A5A, 16'h5A5A);
        tick();
        chk_flags("rst_hold_sub", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_flags("post_rst_sub", 1'b1, 1'b0, 1'b0);

        // Exhaustive small-value ADD; inputs change on even ns, edges fall on odd ns
        @(negedge clk);
        #2;
        for (int x = 0; x < 256; x++) begin
            for (int y = 0; y < 256; y++) begin
                cmd = 4'd0;
                a   = 16'(x);
                b   = 16'(y);
                #1;
                chk("add_sweep", result, 16'(x + y));
                #1;
            end
        end
        tick();
        chk_flags("after_sweep", mz, mv, mn);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] x, y;
            x = 16'($urandom);
            y = 16'($urandom);
            if ((i % 8) == 0) x = 16'h7FFF + 16'($urandom_range(2, 0));
            if ((i % 16) == 1) y = x;
            drive(4'($urandom_range(15, 0)), x, y);
            rr = ref_alu(cmd, a, b);
            chk("rand_res", result, rr.res);
            tick();
            chk_flags("rand", mz, mv, mn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
